// File: rtl/noc_vc_pkg.sv
// Shared definitions for the router input-port VC arbitration logic:
// default VC count, index width derivation, arbiter states and modulo helpers.
package noc_vc_pkg;

  localparam int NUM_VC_DEFAULT = 8;

  function automatic int vc_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Increment modulo n (not modulo a power of two), so n-1 wraps to 0.
  function automatic int unsigned vc_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating first-one finder: returns the first set request at or after ptr,
// wrapping modulo NUM_VC. Purely combinational.
module rr_pick
  import noc_vc_pkg::*;
#(
  parameter int NUM_VC = NUM_VC_DEFAULT,
  parameter int VC_W   = vc_width(NUM_VC)
) (
  input  logic [NUM_VC-1:0] req,
  input  logic [VC_W-1:0]   ptr,
  output logic              any,
  output logic [VC_W-1:0]   idx
);

  logic [NUM_VC-1:0] upper;
  logic [VC_W-1:0]   hi_idx;
  logic [VC_W-1:0]   lo_idx;

  // Requests at or above the pointer take precedence; the lower half is the wrap.
  for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_mask
    assign upper[gi] = req[gi] && (gi >= int'(ptr));
  end

  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      if (upper[i]) hi_idx = VC_W'(i);
      if (req[i])   lo_idx = VC_W'(i);
    end
    any = |req;
    idx = (|upper) ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/vc_rr_arbiter.sv
// Round-robin virtual-channel arbiter with optional head-to-tail packet lock.
// Release re-arbitrates in the same cycle so consecutive grants have no bubble.
module vc_rr_arbiter
  import noc_vc_pkg::*;
#(
  parameter int NUM_VC   = NUM_VC_DEFAULT,
  parameter int VC_W     = vc_width(NUM_VC),
  parameter bit LOCK_PKT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_VC-1:0] vc_req,
  input  logic [NUM_VC-1:0] vc_tail,
  input  logic              out_ready,
  output logic              grant_valid,
  output logic [VC_W-1:0]   grant_idx,
  output logic [NUM_VC-1:0] grant_onehot,
  output logic              xfer,
  output logic [VC_W-1:0]   ptr
);

  arb_state_e      state_reg, state_next;
  logic [VC_W-1:0] owner_reg, owner_next;
  logic [VC_W-1:0] ptr_reg, ptr_next;
  logic [VC_W-1:0] owner_inc;
  logic [VC_W-1:0] pick_ptr;
  logic [VC_W-1:0] pick_idx;
  logic            pick_any;
  logic            release_pkt;

  assign grant_valid = (state_reg == ARB_LOCKED);
  assign xfer        = grant_valid & out_ready & vc_req[owner_reg];
  assign release_pkt = xfer & (vc_tail[owner_reg] | ~LOCK_PKT);
  assign owner_inc   = VC_W'(vc_inc(32'(owner_reg), 32'(NUM_VC)));

  // On release the search starts just past the old owner, so it is considered last.
  assign pick_ptr = release_pkt ? owner_inc : ptr_reg;

  rr_pick #(
    .NUM_VC (NUM_VC),
    .VC_W   (VC_W)
  ) u_pick (
    .req (vc_req),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign grant_idx = grant_valid ? owner_reg : '0;
  assign ptr       = ptr_reg;

  for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_onehot
    assign grant_onehot[gi] = grant_valid && (int'(owner_reg) == gi);
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (pick_any) begin
          owner_next = pick_idx;
          state_next = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (release_pkt) begin
          ptr_next = owner_inc;
          if (pick_any) begin
            owner_next = pick_idx;
          end else begin
            state_next = ARB_IDLE;
          end
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ARB_IDLE;
      owner_reg <= '0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      ptr_reg   <= ptr_next;
    end
  end

endmodule
